// File: rtl/scalar_mul_ram_arbiter.sv
// scalar_mul_ram_arbiter
//   Two-requester round-robin arbiter in front of one port of the scalar
//   multiplier operand RAM. Requester 0 is the host/bus side and requester 1
//   is the point-arithmetic engine. Grants are combinational in the request
//   cycle, and each granted transaction completes in that same cycle. Read
//   data returns one cycle later, qualified by a per-requester rvalid. Writes
//   to STATUS_ADDR are granted but never reach the RAM, and err pulses in the
//   following cycle.
//
//   Optional build macro ARB_LOCK_EN adds req0_lock/req1_lock. A locked
//   owner keeps the grant for at most MAX_LOCK consecutive cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   reqN_req/we/addr/wdata   requester N transaction (held until reqN_gnt)
//   reqN_gnt            requester N granted this cycle (combinational)
//   reqN_rvalid         read data for requester N is on rdata
//   rdata               shared read data (ram_data_out passthrough)
//   err                 one-cycle pulse after a dropped STATUS_ADDR write
//   ram_w/adbus/data_in RAM port drive
//   ram_data_out        RAM read data (registered in the RAM)
//   reqN_lock           (ARB_LOCK_EN only) hold the grant while requesting
module scalar_mul_ram_arbiter #(
  parameter int DATA        = 256,
  parameter int ADDR        = 6,
  parameter int STATUS_ADDR = 0,
  parameter int MAX_LOCK    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_req,
  input  logic            req0_we,
  input  logic [ADDR-1:0] req0_addr,
  input  logic [DATA-1:0] req0_wdata,
  output logic            req0_gnt,
  output logic            req0_rvalid,
  input  logic            req1_req,
  input  logic            req1_we,
  input  logic [ADDR-1:0] req1_addr,
  input  logic [DATA-1:0] req1_wdata,
  output logic            req1_gnt,
  output logic            req1_rvalid,
`ifdef ARB_LOCK_EN
  input  logic            req0_lock,
  input  logic            req1_lock,
`endif
  output logic [DATA-1:0] rdata,
  output logic            err,
  output logic            ram_w,
  output logic [ADDR-1:0] ram_adbus,
  output logic [DATA-1:0] ram_data_in,
  input  logic [DATA-1:0] ram_data_out
);

  // last_q: index of the most recent winner; the other side wins contention.
  logic            last_q;
  logic            any_gnt;
  logic            win;
  logic            win_we;
  logic [ADDR-1:0] win_addr;
  logic [DATA-1:0] win_wdata;
  logic            status_hit;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  // lock_cnt_q counts consecutive locked grants to last_q; zero means no
  // lock is currently owned.
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          hold, forced, other_req, win_lock;
`endif

  always_comb begin
    any_gnt = !rst && (req0_req || req1_req);
    // Contention goes to the side that did not win last; otherwise the
    // lone requester wins.
    win     = (req0_req && req1_req) ? ~last_q : req1_req;
`ifdef ARB_LOCK_EN
    hold      = (lock_cnt_q != '0) &&
                (last_q ? (req1_lock && req1_req) : (req0_lock && req0_req));
    forced    = hold && (lock_cnt_q == CW'(MAX_LOCK));
    other_req = last_q ? req0_req : req1_req;
    // Forced release only hands over if the other side actually wants it.
    if (hold) win = (forced && other_req) ? ~last_q : last_q;
    win_lock  = win ? req1_lock : req0_lock;
    lock_cnt_d = '0;
    if (any_gnt && win_lock)
      lock_cnt_d = (win == last_q && hold && !forced) ? lock_cnt_q + CW'(1) : CW'(1);
`endif
    win_we    = win ? req1_we    : req0_we;
    win_addr  = win ? req1_addr  : req0_addr;
    win_wdata = win ? req1_wdata : req0_wdata;
    status_hit = (win_addr == ADDR'(STATUS_ADDR));
  end

  assign req0_gnt    = any_gnt && !win;
  assign req1_gnt    = any_gnt &&  win;
  assign ram_w       = any_gnt && win_we && !status_hit;
  assign ram_adbus   = any_gnt ? win_addr  : '0;
  assign ram_data_in = any_gnt ? win_wdata : '0;
  assign rdata       = ram_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (any_gnt) last_q <= win;
      req0_rvalid <= req0_gnt && !req0_we;
      req1_rvalid <= req1_gnt && !req1_we;
      err         <= any_gnt && win_we && status_hit;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`endif

endmodule

// File: tb/tb_scalar_mul_ram_arbiter.sv
// Randomized scoreboard bench for scalar_mul_ram_arbiter with a RAM model
// and a transaction-level reference of the arbitration rules.
module tb_scalar_mul_ram_arbiter;
  localparam int DATA = 256, ADDR = 6, MAX_LOCK = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req0_req, req0_we, req1_req, req1_we;
  logic [ADDR-1:0] req0_addr, req1_addr;
  logic [DATA-1:0] req0_wdata, req1_wdata;
  logic req0_gnt, req1_gnt, req0_rvalid, req1_rvalid, err, ram_w;
  logic [ADDR-1:0] ram_adbus;
  logic [DATA-1:0] rdata, ram_data_in, ram_data_out;
  logic req0_lock, req1_lock;

  scalar_mul_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_req(req0_req), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_gnt(req0_gnt), .req0_rvalid(req0_rvalid),
    .req1_req(req1_req), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_gnt(req1_gnt), .req1_rvalid(req1_rvalid),
`ifdef ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rdata(rdata), .err(err), .ram_w(ram_w), .ram_adbus(ram_adbus),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // RAM with registered read.
  logic [DATA-1:0] ram [64];
  always @(posedge clk) begin
    if (ram_w) ram[ram_adbus] <= ram_data_in;
    ram_data_out <= ram[ram_adbus];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic g0, g1, w; logic [ADDR-1:0] a; logic [DATA-1:0] d;} gexp_t;
  typedef struct {int cyc; logic v0, v1, e; logic [DATA-1:0] rd;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Monitor: compares whatever is due this cycle.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    while (gq.size() > 0 && gq[0].cyc <= cyc) begin
      g = gq.pop_front();
      if (g.cyc < cyc) chk("stale grant entry", 1, 0);
      else begin
        chk("req0_gnt", req0_gnt, g.g0);
        chk("req1_gnt", req1_gnt, g.g1);
        chk("ram_w", ram_w, g.w);
        chk("ram_adbus", ram_adbus, g.a);
        chk("ram_data_in", ram_data_in, g.d);
      end
    end
    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      if (r.cyc < cyc) chk("stale response entry", 1, 0);
      else begin
        chk("req0_rvalid", req0_rvalid, r.v0);
        chk("req1_rvalid", req1_rvalid, r.v1);
        chk("err", err, r.e);
        if (r.v0 || r.v1) chk("rdata", rdata, r.rd);
      end
    end
  end

  // Reference model state: who won last, how long the current lock run is,
  // and the RAM contents as the design should have left them.
  int m_ptr, m_run;
  logic [DATA-1:0] m_mem [64];

  // Called at posedge+1: drives one cycle, predicts it, advances to next posedge+1.
  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic [ADDR-1:0] a0, input logic [DATA-1:0] d0,
                      input logic r1, input logic w1, input logic [ADDR-1:0] a1, input logic [DATA-1:0] d1,
                      input logic l0, input logic l1, output int win);
    gexp_t g;
    rexp_t r;
    logic we;
    logic [ADDR-1:0] a;
    logic [DATA-1:0] d;
    rst = rs;
    req0_req = r0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_req = r1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    req0_lock = l0; req1_lock = l1;
    win = -1;
    if (rs) begin
      m_ptr = 1; m_run = 0;
    end else begin
      if (r0 && r1) win = 1 - m_ptr;
      else if (r0) win = 0;
      else if (r1) win = 1;
`ifdef ARB_LOCK_EN
      // A lock run belongs to the last winner while it keeps lock and req.
      if (m_run > 0 && (m_ptr == 0 ? (l0 && r0) : (l1 && r1))) begin
        if (m_run < MAX_LOCK) win = m_ptr;
        else win = ((m_ptr == 0) ? r1 : r0) ? 1 - m_ptr : m_ptr;
      end
      if (win >= 0 && (win == 0 ? l0 : l1))
        m_run = (win == m_ptr && m_run > 0 && m_run < MAX_LOCK) ? m_run + 1 : 1;
      else m_run = 0;
`endif
    end
    g = '{cyc: cyc, g0: 1'b0, g1: 1'b0, w: 1'b0, a: '0, d: '0};
    r = '{cyc: cyc + 1, v0: 1'b0, v1: 1'b0, e: 1'b0, rd: '0};
    if (win >= 0) begin
      we = (win == 0) ? w0 : w1;
      a  = (win == 0) ? a0 : a1;
      d  = (win == 0) ? d0 : d1;
      g.g0 = (win == 0); g.g1 = (win == 1);
      g.a = a; g.d = d;
      g.w = we && (a != 0);
      r.e = we && (a == 0);
      if (!we) begin
        r.v0 = (win == 0); r.v1 = (win == 1); r.rd = m_mem[a];
      end
      if (g.w) m_mem[a] = d;
      m_ptr = win;
    end
    gq.push_back(g);
    rq.push_back(r);
    @(posedge clk); #1;
  endtask

  function automatic logic [DATA-1:0] rnd256();
    logic [DATA-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int w;
    logic p0, p1, pw0, pw1;
    logic [ADDR-1:0] pa0, pa1;
    logic [DATA-1:0] pd0, pd1;
    for (int i = 0; i < 64; i++) begin ram[i] = '0; m_mem[i] = '0; end
    m_ptr = 1; m_run = 0;
    rst = 1'b1;
    req0_req = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_req = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    req0_lock = 0; req1_lock = 0;
    @(posedge clk); #1;

    // Reset holds grants off even with a request present.
    step(1, 1, 0, 6'd5, '0, 0, 0, '0, '0, 0, 0, w);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    // Seed RAM[5]=0xABCD, then lone read by requester 0.
    step(0, 0, 0, '0, '0, 1, 1, 6'd5, 256'hABCD, 0, 0, w);
    step(0, 1, 0, 6'd5, '0, 0, 0, '0, '0, 0, 0, w);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    // Continuous contention of reads: alternate grants.
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 6'd2, '0, 1, 0, 6'd3, '0, 0, 0, w);
    // Write by 1 then read back by 0.
    step(0, 0, 0, '0, '0, 1, 1, 6'd7, 256'h1234, 0, 0, w);
    step(0, 1, 0, 6'd7, '0, 0, 0, '0, '0, 0, 0, w);
    // Status-address write: granted, dropped, err next cycle.
    step(0, 1, 1, 6'd0, 256'hDEAD, 0, 0, '0, '0, 0, 0, w);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    // Read by 1, then reset, then contention after release favours 0.
    step(0, 0, 0, '0, '0, 1, 0, 6'd7, '0, 0, 0, w);
    step(1, 1, 0, 6'd5, '0, 1, 0, 6'd7, '0, 0, 0, w);
    step(0, 1, 0, 6'd5, '0, 1, 0, 6'd7, '0, 0, 0, w);
    step(0, 0, 0, '0, '0, 1, 0, 6'd7, '0, 0, 0, w);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
`ifdef ARB_LOCK_EN
    // Locked requester 0 against a persistent requester 1.
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 6'd2, '0, 1, 0, 6'd3, '0, 1, 0, w);
`endif

    // Random phase; requests are held until granted.
    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 3000; n++) begin
      logic rs, l0, l1;
      if (!p0 && ($urandom % 4) != 0) begin
        p0 = 1; pw0 = $urandom % 2; pa0 = ADDR'($urandom % 8); pd0 = rnd256();
      end
      if (!p1 && ($urandom % 4) != 0) begin
        p1 = 1; pw1 = $urandom % 2; pa1 = ADDR'($urandom % 8); pd1 = rnd256();
      end
      rs = (($urandom % 64) == 0);
      l0 = (($urandom % 3) == 0);
      l1 = (($urandom % 3) == 0);
      step(rs, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, l0, l1, w);
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 0;
    end
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, w);
    @(posedge clk); #1;
    chk("scoreboard drained", DATA'(gq.size() + rq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
